// File: rtl/edge_pkg.sv
// Shared definitions for the edge-detector frame sequencer.
//   seqState_t : sequencer FSM states
//   DEF_*      : default image/kernel/buffer sizes
//   nIn/nOut   : pixels entering / leaving the edge-detector core per frame
package edge_pkg;

  localparam int unsigned DEF_IMG_X_SIZE     = 100;
  localparam int unsigned DEF_IMG_Y_SIZE     = 100;
  localparam int unsigned DEF_KX_SIZE        = 3;
  localparam int unsigned DEF_KY_SIZE        = 3;
  localparam int unsigned DEF_OUT_FIFO_DEPTH = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    LOAD,
    RUN,
    DRAIN
  } seqState_t;

  function automatic int unsigned nIn(input int unsigned xSize, input int unsigned ySize);
    return xSize * ySize;
  endfunction

  function automatic int unsigned nOut(input int unsigned xSize, input int unsigned ySize,
                                       input int unsigned kx, input int unsigned ky);
    return (xSize - kx + 1) * (ySize - ky + 1);
  endfunction

endpackage

// File: rtl/edge_out_fifo.sv
// Synchronous output buffer for core result pixels.
//   clk, rstN        : clock, synchronous active-low reset (empties the buffer)
//   push, pushData   : write request; ignored when full unless a pop happens the same cycle
//   pop              : read request; ignored when empty
//   popData          : head entry (valid while !empty)
//   full, empty      : occupancy flags
// DEPTH must be a power of two and >= 2.
module edge_out_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] popData,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wrPtr;
  logic [AW:0]      rdPtr;
  logic             doPush;
  logic             doPop;

  assign empty   = (wrPtr == rdPtr);
  assign full    = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign doPop   = pop && !empty;
  // A pop frees the head slot this edge, so a write on full still fits.
  assign doPush  = push && (!full || doPop);
  assign popData = mem[rdPtr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rstN) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr[AW-1:0]] <= pushData;
  end

endmodule

// File: rtl/edge_frame_sequencer.sv
// Frame sequencer between an Avalon-ST pixel stream and an edge-detector core.
// Accepts one gray frame (sop-delimited) from the sink, starts the core and
// feeds it N_IN pixels, buffers the N_OUT core results and streams them out
// on the source with sop/eop framing.
//   clk_i, rst_i                 : clock, synchronous active-low reset
//   snk_*                        : Avalon-ST sink (data/valid/sop/eop/ready)
//   src_*                        : Avalon-ST source (data/valid/sop/eop/ready)
//   core_start_o/core_pixel_o/core_data_available_o : feed to core
//   core_valid_i/core_pixel_i    : core results (core cannot stall)
//   busy_o                       : frame in progress
//   overflow_o                   : sticky, a core result was dropped
//   frame_err_o                  : sticky framing error (only with FRAME_CHECK_EN)
// Optional feature macro: FRAME_CHECK_EN (sop/eop framing checks during load).
module edge_frame_sequencer
  import edge_pkg::*;
#(
  parameter int unsigned IMG_X_SIZE     = DEF_IMG_X_SIZE,
  parameter int unsigned IMG_Y_SIZE     = DEF_IMG_Y_SIZE,
  parameter int unsigned KX_SIZE        = DEF_KX_SIZE,
  parameter int unsigned KY_SIZE        = DEF_KY_SIZE,
  parameter int unsigned OUT_FIFO_DEPTH = DEF_OUT_FIFO_DEPTH
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] snk_data_i,
  input  logic       snk_valid_i,
  input  logic       snk_sop_i,
  input  logic       snk_eop_i,
  output logic       snk_ready_o,
  output logic [7:0] src_data_o,
  output logic       src_valid_o,
  output logic       src_sop_o,
  output logic       src_eop_o,
  input  logic       src_ready_i,
  output logic       core_start_o,
  output logic [7:0] core_pixel_o,
  output logic       core_data_available_o,
  input  logic       core_valid_i,
  input  logic [7:0] core_pixel_i,
  output logic       busy_o,
`ifdef FRAME_CHECK_EN
  output logic       frame_err_o,
`endif
  output logic       overflow_o
);

  localparam int unsigned N_IN  = nIn(IMG_X_SIZE, IMG_Y_SIZE);
  localparam int unsigned N_OUT = nOut(IMG_X_SIZE, IMG_Y_SIZE, KX_SIZE, KY_SIZE);
  localparam int unsigned IW    = $clog2(N_IN + 1);
  localparam int unsigned OW    = $clog2(N_OUT + 1);
  localparam logic [IW-1:0] IN_LAST  = IW'(N_IN - 1);
  localparam logic [OW-1:0] OUT_LAST = OW'(N_OUT - 1);

  seqState_t     state;
  seqState_t     stateNext;
  logic [7:0]    pixel0;
  logic [IW-1:0] inCnt;
  logic [OW-1:0] coreCnt;
  logic [OW-1:0] outCnt;
  logic          overflow;
  logic          frameAccept;
  logic          pix0Bad;
  logic          loadBad;
  logic          coreValidRun;
  logic          srcValid;
  logic          fifoPop;
  logic          fifoFull;
  logic          fifoEmpty;
  logic [7:0]    fifoHead;

`ifdef FRAME_CHECK_EN
  logic          frameErr;
  logic          errSet;

  assign pix0Bad = snk_eop_i && (IN_LAST != '0);
  assign loadBad = snk_sop_i || (snk_eop_i && (inCnt != IN_LAST));
  assign errSet  = snk_valid_i && (((state == IDLE) && snk_sop_i && pix0Bad) ||
                                   ((state == LOAD) && loadBad));
`else
  logic          unusedEop;

  assign pix0Bad   = 1'b0;
  assign loadBad   = 1'b0;
  assign unusedEop = snk_eop_i;
`endif

  always_comb begin
    stateNext             = state;
    snk_ready_o           = 1'b0;
    core_start_o          = 1'b0;
    core_pixel_o          = '0;
    core_data_available_o = 1'b0;
    frameAccept           = 1'b0;
    if (rst_i) begin
      case (state)
        IDLE: begin
          snk_ready_o = 1'b1;
          if (snk_valid_i && snk_sop_i && !pix0Bad) begin
            frameAccept = 1'b1;
            stateNext   = START;
          end
        end
        START: begin
          core_start_o          = 1'b1;
          core_pixel_o          = pixel0;
          core_data_available_o = 1'b1;
          stateNext             = (IN_LAST == '0) ? RUN : LOAD;
        end
        LOAD: begin
          snk_ready_o = 1'b1;
          if (snk_valid_i) begin
            if (loadBad) begin
              stateNext = IDLE;
            end else begin
              core_pixel_o          = snk_data_i;
              core_data_available_o = 1'b1;
              if (inCnt == IN_LAST) stateNext = RUN;
            end
          end
        end
        RUN: begin
          if (core_valid_i && (coreCnt == OUT_LAST)) stateNext = DRAIN;
        end
        DRAIN: begin
          if (fifoEmpty) stateNext = IDLE;
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  assign coreValidRun = core_valid_i && (state == RUN);
  assign srcValid     = rst_i && !fifoEmpty;
  assign fifoPop      = srcValid && src_ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      pixel0   <= '0;
      inCnt    <= '0;
      coreCnt  <= '0;
      outCnt   <= '0;
      overflow <= 1'b0;
    end else begin
      state <= stateNext;
      if ((state == LOAD) && snk_valid_i) inCnt <= inCnt + 1'b1;
      if (coreValidRun) coreCnt <= coreCnt + 1'b1;
      if (fifoPop) outCnt <= outCnt + 1'b1;
      if (coreValidRun && fifoFull && !fifoPop) overflow <= 1'b1;
      // Pixel 0 is held for the START cycle; the frame counters restart here.
      if (frameAccept) begin
        pixel0  <= snk_data_i;
        inCnt   <= IW'(1);
        coreCnt <= '0;
        outCnt  <= '0;
      end
    end
  end

`ifdef FRAME_CHECK_EN
  always_ff @(posedge clk_i) begin
    if (!rst_i)      frameErr <= 1'b0;
    else if (errSet) frameErr <= 1'b1;
  end

  assign frame_err_o = rst_i && frameErr;
`endif

  edge_out_fifo #(
    .DEPTH(OUT_FIFO_DEPTH),
    .WIDTH(8)
  ) outFifo (
    .clk     (clk_i),
    .rstN    (rst_i),
    .push    (coreValidRun),
    .pushData(core_pixel_i),
    .pop     (fifoPop),
    .popData (fifoHead),
    .full    (fifoFull),
    .empty   (fifoEmpty)
  );

  assign src_valid_o = srcValid;
  assign src_data_o  = srcValid ? fifoHead : '0;
  assign src_sop_o   = srcValid && (outCnt == '0);
  assign src_eop_o   = srcValid && (outCnt == OUT_LAST);
  assign busy_o      = rst_i && (state != IDLE);
  assign overflow_o  = rst_i && overflow;

endmodule
